// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: volleyball match sequencer.
// Walks IDLE -> SERVE -> RALLY -> SCORED -> (SERVE | OVER), detects ball
// landings from the ball position, keeps both scores and times the pauses.
// Optional feature macro: GAME_AUTO_RESTART_EN (OVER returns to IDLE by
// itself after OVER_DELAY cycles instead of waiting for a start press).
module game_flow_ctrl #(
  parameter int unsigned SERVE_DELAY = 50_000_000,
  parameter int unsigned POINT_DELAY = 50_000_000,
  parameter int unsigned OVER_DELAY  = 150_000_000,
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned FLOOR_Y     = 220,
  parameter int unsigned BALL_H      = 30,
  parameter int unsigned BALL_W      = 30,
  parameter int unsigned NET_CX      = 163
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  score_player,
  output logic [3:0]  score_npc,
  output logic        point_pulse,
  output logic        match_winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_RALLY,
    S_SCORED,
    S_OVER
  } state_t;

  localparam logic [31:0] SERVE_LAST = 32'(SERVE_DELAY - 1);
  localparam logic [31:0] POINT_LAST = 32'(POINT_DELAY - 1);
`ifdef GAME_AUTO_RESTART_EN
  localparam logic [31:0] OVER_LAST  = 32'(OVER_DELAY - 1);
`endif
  localparam logic [3:0]  WIN_PTS    = 4'(WIN_SCORE);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_start_q;
  logic [1:0]  r_game_state;
  logic        r_who_win;
  logic [3:0]  r_score_player;
  logic [3:0]  r_score_npc;
  logic        r_point_pulse;
  logic        r_match_winner;

  logic        w_start_rise;
  logic [12:0] w_ball_bottom;
  logic [12:0] w_ball_centre;
  logic        w_land;
  logic        w_left_court;
  logic [3:0]  w_player_inc;
  logic [3:0]  w_npc_inc;
  logic [3:0]  w_winner_score;

  // Ball geometry is evaluated in 13 bits so the sums never wrap.
  assign w_start_rise   = start_btn & ~r_start_q;
  assign w_ball_bottom  = {1'b0, Ball_Y} + 13'(BALL_H);
  assign w_ball_centre  = {1'b0, Ball_X} + 13'(BALL_W / 2);
  assign w_land         = (w_ball_bottom >= 13'(FLOOR_Y));
  assign w_left_court   = (w_ball_centre < 13'(NET_CX));
  assign w_player_inc   = (r_score_player == 4'hF) ? 4'hF : r_score_player + 4'd1;
  assign w_npc_inc      = (r_score_npc == 4'hF) ? 4'hF : r_score_npc + 4'd1;
  assign w_winner_score = r_who_win ? r_score_npc : r_score_player;

  // Match FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= 32'd0;
      r_start_q      <= 1'b0;
      r_game_state   <= 2'd0;
      r_who_win      <= 1'b0;
      r_score_player <= 4'd0;
      r_score_npc    <= 4'd0;
      r_point_pulse  <= 1'b0;
      r_match_winner <= 1'b0;
    end else begin
      r_start_q     <= start_btn;
      r_point_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_rise) begin
            r_score_player <= 4'd0;
            r_score_npc    <= 4'd0;
            r_who_win      <= 1'b0;
            r_cnt          <= 32'd0;
            r_state        <= S_SERVE;
            r_game_state   <= 2'd1;
          end
        end
        S_SERVE: begin
          if (r_cnt == SERVE_LAST) begin
            r_cnt        <= 32'd0;
            r_state      <= S_RALLY;
            r_game_state <= 2'd2;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RALLY: begin
          // A landing on the left half is a point for the NPC.
          if (w_land) begin
            if (w_left_court) begin
              r_score_npc <= w_npc_inc;
              r_who_win   <= 1'b1;
            end else begin
              r_score_player <= w_player_inc;
              r_who_win      <= 1'b0;
            end
            r_point_pulse <= 1'b1;
            r_cnt         <= 32'd0;
            r_state       <= S_SCORED;
            r_game_state  <= 2'd1;
          end
        end
        S_SCORED: begin
          if (r_cnt == POINT_LAST) begin
            r_cnt <= 32'd0;
            if (w_winner_score >= WIN_PTS) begin
              r_match_winner <= r_who_win;
              r_state        <= S_OVER;
              r_game_state   <= 2'd3;
            end else begin
              r_state      <= S_SERVE;
              r_game_state <= 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_OVER: begin
`ifdef GAME_AUTO_RESTART_EN
          if (r_cnt == OVER_LAST) begin
            r_cnt          <= 32'd0;
            r_score_player <= 4'd0;
            r_score_npc    <= 4'd0;
            r_who_win      <= 1'b0;
            r_match_winner <= 1'b0;
            r_state        <= S_IDLE;
            r_game_state   <= 2'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
`else
          if (w_start_rise) begin
            r_cnt          <= 32'd0;
            r_score_player <= 4'd0;
            r_score_npc    <= 4'd0;
            r_who_win      <= 1'b0;
            r_state        <= S_SERVE;
            r_game_state   <= 2'd1;
          end
`endif
        end
        default: begin
          r_cnt        <= 32'd0;
          r_state      <= S_IDLE;
          r_game_state <= 2'd0;
        end
      endcase
    end
  end

  assign Game_state   = r_game_state;
  assign who_win      = r_who_win;
  assign score_player = r_score_player;
  assign score_npc    = r_score_npc;
  assign point_pulse  = r_point_pulse;
  assign match_winner = r_match_winner;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: table-driven cycle vectors for game_flow_ctrl plus a few
// hand-written multi-cycle sequences (held start button, NPC match win).
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_btn = 1'b0;
  logic [11:0] Ball_X = 12'd40;
  logic [11:0] Ball_Y = 12'd0;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  score_player;
  logic [3:0]  score_npc;
  logic        point_pulse;
  logic        match_winner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .SERVE_DELAY(4),
    .POINT_DELAY(3),
    .OVER_DELAY (5),
    .WIN_SCORE  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_btn   (start_btn),
    .Ball_X      (Ball_X),
    .Ball_Y      (Ball_Y),
    .Game_state  (Game_state),
    .who_win     (who_win),
    .score_player(score_player),
    .score_npc   (score_npc),
    .point_pulse (point_pulse),
    .match_winner(match_winner)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [11:0] bx;
    logic [11:0] by;
    logic [1:0]  gs;
    logic        ww;
    logic [3:0]  sp;
    logic [3:0]  sn;
    logic        pp;
    logic        mw;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst, input logic st, input int bx, input int by,
                     input int gs, input logic ww, input int sp, input int sn,
                     input logic pp, input logic mw);
    vec_t v;
    v.rst = rst; v.st = st; v.bx = 12'(bx); v.by = 12'(by);
    v.gs = 2'(gs); v.ww = ww; v.sp = 4'(sp); v.sn = 4'(sn); v.pp = pp; v.mw = mw;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic wait_gs(input string name, input logic [1:0] target, input int budget);
    int n;
    n = 0;
    while (Game_state != target && n < budget) begin
      step();
      n++;
    end
    check(name, int'(Game_state), int'(target));
  endtask

  function automatic logic [12:0] pack_out();
    return {Game_state, who_win, score_player, score_npc, point_pulse, match_winner};
  endfunction

  initial begin
    logic [12:0] exp_v;
    logic [12:0] act_v;
    logic [1:0]  prev_gs;
    int          serve_entries;

    // rst st  bx   by   gs ww sp sn pp mw
    row(1, 0,  40,   0,  0, 0, 0, 0, 0, 0);   // 0 reset
    row(0, 0,  40,   0,  0, 0, 0, 0, 0, 0);   // 1 idle
    row(0, 1,  40,   0,  1, 0, 0, 0, 0, 0);   // 2 start edge -> SERVE
    for (int i = 0; i < 3; i++) row(0, 0, 40, 0, 1, 0, 0, 0, 0, 0);
    row(0, 0,  40,   0,  2, 0, 0, 0, 0, 0);   // 6 RALLY (t+5 after row 2's edge... t+4 edges)
    row(0, 0,  40,   0,  2, 0, 0, 0, 0, 0);   // 7
    row(0, 0,  40, 190,  1, 1, 0, 1, 1, 0);   // 8 left landing, NPC point
    for (int i = 0; i < 3; i++) row(0, 0, 40, 0, 1, 1, 0, 1, 0, 0);  // SCORED, then SERVE
    for (int i = 0; i < 3; i++) row(0, 0, 40, 0, 1, 1, 0, 1, 0, 0);  // SERVE
    row(0, 0,  40,   0,  2, 1, 0, 1, 0, 0);   // 15 RALLY
    row(0, 0, 200, 189,  2, 1, 0, 1, 0, 0);   // 16 just above floor: no point
    row(0, 0, 200, 195,  1, 0, 1, 1, 1, 0);   // 17 right landing, player point
    for (int i = 0; i < 6; i++) row(0, 0, 40, 0, 1, 0, 1, 1, 0, 0);
    row(0, 0,  40,   0,  2, 0, 1, 1, 0, 0);   // 24 RALLY
    row(0, 1,  40,   0,  2, 0, 1, 1, 0, 0);   // 25 press in RALLY ignored
    row(0, 0,  40,   0,  2, 0, 1, 1, 0, 0);   // 26
    row(0, 0, 200, 195,  1, 0, 2, 1, 1, 0);   // 27 player reaches WIN_SCORE
    row(0, 0,  40,   0,  1, 0, 2, 1, 0, 0);   // 28
    row(0, 0,  40,   0,  1, 0, 2, 1, 0, 0);   // 29
    row(0, 0,  40,   0,  3, 0, 2, 1, 0, 0);   // 30 OVER, player won
`ifdef GAME_AUTO_RESTART_EN
    for (int i = 0; i < 4; i++) row(0, 0, 40, 0, 3, 0, 2, 1, 0, 0);
    row(0, 0,  40,   0,  0, 0, 0, 0, 0, 0);   // 35 auto-restart to IDLE
`else
    for (int i = 0; i < 5; i++) row(0, 0, 40, 0, 3, 0, 2, 1, 0, 0);  // holds
`endif
    row(0, 1,  40,   0,  1, 0, 0, 0, 0, 0);   // 36 start -> SERVE, scores cleared
    for (int i = 0; i < 3; i++) row(0, 0, 40, 0, 1, 0, 0, 0, 0, 0);
    row(0, 0,  40,   0,  2, 0, 0, 0, 0, 0);   // 40 RALLY
    row(0, 0,  40, 200,  1, 1, 0, 1, 1, 0);   // 41 NPC point -> SCORED
    row(1, 0,  40,   0,  0, 0, 0, 0, 0, 0);   // 42 reset in SCORED
    row(0, 0,  40,   0,  0, 0, 0, 0, 0, 0);   // 43 stays IDLE

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      start_btn = vecs[i].st;
      Ball_X    = vecs[i].bx;
      Ball_Y    = vecs[i].by;
      step();
      exp_v = {vecs[i].gs, vecs[i].ww, vecs[i].sp, vecs[i].sn, vecs[i].pp, vecs[i].mw};
      act_v = pack_out();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL row%0d gs/ww/sp/sn/pp/mw actual=%0d/%0d/%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d/%0d/%0d",
                 i, Game_state, who_win, score_player, score_npc, point_pulse, match_winner,
                 vecs[i].gs, vecs[i].ww, vecs[i].sp, vecs[i].sn, vecs[i].pp, vecs[i].mw);
      end else begin
        $display("ok   row%0d gs=%0d ww=%0d sp=%0d sn=%0d pp=%0d mw=%0d",
                 i, Game_state, who_win, score_player, score_npc, point_pulse, match_winner);
      end
    end

    // Start held high through IDLE: exactly one SERVE entry, then RALLY.
    Ball_X = 12'd40;
    Ball_Y = 12'd0;
    start_btn = 1'b1;
    prev_gs = Game_state;
    serve_entries = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (prev_gs == 2'd0 && Game_state == 2'd1) serve_entries++;
      prev_gs = Game_state;
    end
    check("held_start_serve_entries", serve_entries, 1);
    check("held_start_in_rally", int'(Game_state), 2);
    start_btn = 1'b0;
    step();

    // NPC wins the match with two left-court landings.
    Ball_Y = 12'd200;
    step();
    check("npc1_score", int'(score_npc), 1);
    check("npc1_pulse", int'(point_pulse), 1);
    Ball_Y = 12'd0;
    step();
    check("npc1_pulse_one_cycle", int'(point_pulse), 0);
    wait_gs("npc_back_to_rally", 2'd2, 20);
    Ball_Y = 12'd200;
    step();
    check("npc2_score", int'(score_npc), 2);
    Ball_Y = 12'd0;
    wait_gs("npc_match_over", 2'd3, 20);
    check("npc_match_winner", int'(match_winner), 1);
    check("npc_who_win", int'(who_win), 1);

    reset = 1'b1;
    step();
    check("final_reset_state", int'(Game_state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
